// File: rtl/calc_div_sub_pkg.sv
// calc_div_sub_pkg: shared modes, state encoding and default widths for the calculator units
package calc_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_MUL = 1'b1;
  localparam logic MODE_DIV = 1'b1;
  localparam int CALC_A_W = 8;
  localparam int CALC_B_W = 4;
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
endpackage

// File: rtl/calc_div_sub_if.sv
// calc_div_sub_if: operand/launch and result/handshake bundle between switches, LEDs and the unit
interface calc_div_sub_if #(parameter int A_W = calc_pkg::CALC_A_W, parameter int B_W = calc_pkg::CALC_B_W);
  logic start;
  logic mode;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic busy;
  logic done;
  logic [A_W-1:0] result;
  logic [B_W-1:0] rem;
  logic borrow;
  logic div0;
  modport master(output start, mode, a, b, input busy, done, result, rem, borrow, div0);
  modport slave(input start, mode, a, b, output busy, done, result, rem, borrow, div0);
endinterface

// File: rtl/calc_div_sub_div_step.sv
// div_step: one combinational restoring-division iteration
module div_step import calc_pkg::*; #(parameter int B_W = CALC_B_W) (
  input  logic [B_W:0]   part,
  input  logic           din,
  input  logic [B_W-1:0] dvs,
  output logic [B_W:0]   part_n,
  output logic           q
);
  logic [B_W:0] p;
  assign p = {part[B_W-1:0], din};
  assign q = p >= {1'b0, dvs};
  assign part_n = q ? p - {1'b0, dvs} : p;
endmodule

// File: rtl/calc_div_sub.sv
// calc_div_sub: single-cycle subtract or multi-cycle restoring divide with busy/done handshake
module calc_div_sub import calc_pkg::*; #(parameter int A_W = CALC_A_W, parameter int B_W = CALC_B_W) (
  input logic clk,
  input logic rst,
  calc_div_sub_if.slave bus
);
  localparam int CW = $clog2(A_W);
  state_t state;
  logic [A_W-1:0] dvd, result;
  logic [B_W:0] part, part_n;
  logic [B_W-1:0] dvs, rem;
  logic [CW-1:0] cnt;
  logic busy, done, borrow, div0, bw_s, d0_s, q;
  div_step #(.B_W(B_W)) u_step (.part(part), .din(dvd[A_W-1]), .dvs(dvs), .part_n(part_n), .q(q));
  // dvd/part/bw_s/d0_s stage the pending result so all outputs publish together in FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dvd <= '0;
      part <= '0;
      dvs <= '0;
      cnt <= '0;
      bw_s <= 1'b0;
      d0_s <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      rem <= '0;
      borrow <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          part <= '0;
          if (bus.mode == MODE_SUB) begin
            dvd <= bus.a - A_W'(bus.b);
            bw_s <= bus.a < A_W'(bus.b);
            d0_s <= 1'b0;
            state <= FIN;
          end else if (bus.b == '0) begin
            dvd <= '1;
            bw_s <= 1'b0;
            d0_s <= 1'b1;
            state <= FIN;
          end else begin
            dvd <= bus.a;
            dvs <= bus.b;
            cnt <= CW'(A_W - 1);
            bw_s <= 1'b0;
            d0_s <= 1'b0;
            busy <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          part <= part_n;
          dvd <= {dvd[A_W-2:0], q};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            busy <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          done <= 1'b1;
          result <= dvd;
          rem <= part[B_W-1:0];
          borrow <= bw_s;
          div0 <= d0_s;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.result = result;
  assign bus.rem = rem;
  assign bus.borrow = borrow;
  assign bus.div0 = div0;
endmodule

// File: tb/tb_calc_div_sub.sv
// tb_calc_div_sub: directed checks of subtract, divide, divide-by-zero, dropped starts and reset abort
module tb_calc_div_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int lat, bcnt, dn, dk;
  calc_div_sub_if #(.A_W(8), .B_W(4)) bus ();
  calc_div_sub dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic m, input logic [7:0] aa, input logic [3:0] bb, output int l, output int bc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.a = aa;
    bus.b = bb;
    l = -1;
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        bus.start = 1'b0;
        bus.mode = ~m;
        bus.a = ~aa;
        bus.b = ~bb;
      end
      bc += int'(bus.busy);
      if (bus.done) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_borrow", bus.borrow, 0);
    chk("rst_div0", bus.div0, 0);
    @(negedge clk);
    rst = 1'b0;

    op(1'b0, 8'd200, 4'd13, lat, bcnt);
    chk("sub1_lat", lat, 1);
    chk("sub1_result", bus.result, 8'hBB);
    chk("sub1_borrow", bus.borrow, 0);
    chk("sub1_rem", bus.rem, 0);
    op(1'b0, 8'd5, 4'd9, lat, bcnt);
    chk("sub2_result", bus.result, 8'hFC);
    chk("sub2_borrow", bus.borrow, 1);
    op(1'b0, 8'd0, 4'd15, lat, bcnt);
    chk("sub3_result", bus.result, 8'hF1);
    chk("sub3_borrow", bus.borrow, 1);
    op(1'b0, 8'd15, 4'd15, lat, bcnt);
    chk("sub4_result", bus.result, 8'h00);
    chk("sub4_borrow", bus.borrow, 0);

    op(1'b1, 8'd200, 4'd7, lat, bcnt);
    chk("div1_lat", lat, 9);
    chk("div1_busy_cycles", bcnt, 8);
    chk("div1_result", bus.result, 28);
    chk("div1_rem", bus.rem, 4);
    chk("div1_div0", bus.div0, 0);
    chk("div1_borrow", bus.borrow, 0);
    op(1'b1, 8'd143, 4'd11, lat, bcnt);
    chk("div2_result", bus.result, 13);
    chk("div2_rem", bus.rem, 0);

    op(1'b1, 8'd77, 4'd0, lat, bcnt);
    chk("dz_lat", lat, 1);
    chk("dz_result", bus.result, 8'hFF);
    chk("dz_rem", bus.rem, 0);
    chk("dz_div0", bus.div0, 1);
    chk("dz_borrow", bus.borrow, 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.a = 8'd200;
    bus.b = 4'd7;
    dn = 0;
    dk = -1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.start = 1'b0;
      if (k == 2) begin
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.a = 8'd100;
        bus.b = 4'd3;
      end
      if (k == 3) bus.start = 1'b0;
      if (k == 4) begin
        chk("hold_result", bus.result, 8'hFF);
        chk("hold_div0", bus.div0, 1);
        chk("mid_busy", bus.busy, 1);
      end
      if (bus.done) begin
        dn++;
        dk = k;
      end
    end
    chk("dbl_ndone", dn, 1);
    chk("dbl_lat", dk, 9);
    chk("dbl_result", bus.result, 28);
    chk("dbl_rem", bus.rem, 4);

    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.a = 8'd143;
    bus.b = 4'd11;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.start = 1'b0;
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_rem", bus.rem, 0);
        chk("abort_done", bus.done, 0);
      end
      if (bus.done) dn++;
    end
    chk("abort_ndone", dn, 0);
    op(1'b1, 8'd143, 4'd11, lat, bcnt);
    chk("fresh_lat", lat, 9);
    chk("fresh_result", bus.result, 13);
    chk("fresh_rem", bus.rem, 0);

    for (int av = 0; av < 256; av++) begin
      for (int bv = 1; bv < 16; bv++) begin
        op(1'b1, 8'(av), 4'(bv), lat, bcnt);
        chk("sweep_q", bus.result, av / bv);
        chk("sweep_inv", int'(bus.result) * bv + int'(bus.rem), av);
        chk("sweep_rem_lt", {31'b0, int'(bus.rem) < bv}, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
